usr_shift_register: RTL and testbench

- Parametrised universal shift register; the next generation of the team's 8-bit parallel-in/parallel-out register.
- Adds to parallel load:
  - multi-cycle shifts by a programmable amount: logical left/right, rotate left/right, arithmetic right;
  - serial in/out on both ends;
  - start/busy/done handshake.
- Used as a datapath staging register and as a serialiser/deserialiser in peripheral blocks.

---
 rtl/usr_shift_register_if.sv | 31 +++
 rtl/usr_shift_register.sv | 125 ++++++++++++
 tb/tb_usr_shift_register.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/usr_shift_register_if.sv
// Handshake/data bundle for usr_shift_register; master drives requests, slave returns register state.
// The parity signal exists only when USR_PARITY_EN is defined.
interface usr_shift_register_if #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] din;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;

  modport master (output start, op, amt, din, sin_l, sin_r,
                  input  q, sout_l, sout_r, busy, done, parity);
  modport slave  (input  start, op, amt, din, sin_l, sin_r,
                  output q, sout_l, sout_r, busy, done, parity);
`else
  modport master (output start, op, amt, din, sin_l, sin_r,
                  input  q, sout_l, sout_r, busy, done);
  modport slave  (input  start, op, amt, din, sin_l, sin_r,
                  output q, sout_l, sout_r, busy, done);
`endif
endinterface

// File: rtl/usr_shift_register.sv
// Universal shift register: load/clear, multi-cycle shift/rotate by a saturating amount, start/busy/done.
// Optional registered parity output of q is enabled by defining USR_PARITY_EN.
module usr_shift_register #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  usr_shift_register_if.slave bus
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [AW-1:0]    n_sat;
  logic             busy_r;
  logic             done_r;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] shift1(input logic [2:0] o, input logic [WIDTH-1:0] v,
                                              input logic sl, input logic sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (o)
      OP_SHL:  r = {v[WIDTH-2:0], sr};
      OP_SHR:  r = {sl, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    n_sat    = (bus.amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.amt;
    is_shift = (bus.op >= OP_SHL) && (bus.op <= OP_ASR);
  end

  // Serial inputs feed shift1 live on every RUN edge so callers can stream bits in.
  always_comb begin
    q_nxt = q_r;
    if (state == IDLE) begin
      if (bus.start) begin
        case (bus.op)
          OP_LOAD: q_nxt = bus.din;
          OP_CLR:  q_nxt = '0;
          default: q_nxt = q_r;
        endcase
      end
    end else begin
      q_nxt = shift1(op_r, q_r, bus.sin_l, bus.sin_r);
    end
  end

`ifdef USR_PARITY_EN
  logic parity_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= OP_NOP;
      cnt    <= '0;
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef USR_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      q_r    <= q_nxt;
      done_r <= 1'b0;
`ifdef USR_PARITY_EN
      parity_r <= ^q_nxt;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            if (is_shift && (n_sat != '0)) begin
              state  <= RUN;
              busy_r <= 1'b1;
              cnt    <= n_sat;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
`ifdef USR_PARITY_EN
  assign bus.parity = parity_r;
`endif

endmodule

// File: tb/tb_usr_shift_register.sv
// Directed-vector bench for usr_shift_register (WIDTH=8); parity checks compile in with USR_PARITY_EN.
module tb_usr_shift_register;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   bcnt;
  int   lat;

  usr_shift_register_if #(.WIDTH(8)) bus ();

  usr_shift_register #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge and leave right after the accepting edge (E0).
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
    bus.start = 1'b1;
    bus.op    = o;
    bus.amt   = a;
    bus.din   = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // From just after E0: count busy cycles and edges until done is seen, bounded.
  task automatic wait_done(input string tag, output int b, output int edges);
    b     = 0;
    edges = 0;
    while (!bus.done && edges < 200) begin
      if (bus.busy) b++;
      @(negedge clk);
      edges++;
    end
    if (!bus.done) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.amt   = '0;
    bus.din   = '0;
    bus.sin_l = 1'b0;
    bus.sin_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", bus.q, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
`ifdef USR_PARITY_EN
    chk("rst_parity", bus.parity, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Load 0xCC: one edge, single done pulse, never busy.
    issue(3'b001, 4'd0, 8'hCC);
    chk("load_q", bus.q, 8'hCC);
    chk("load_done", bus.done, 1'b1);
    chk("load_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("load_done_drop", bus.done, 1'b0);
    chk("load_busy2", bus.busy, 1'b0);

    // ROL by 3 on A5, stepping 4B, 96, 2D.
    issue(3'b001, 4'd0, 8'hA5);
    @(negedge clk);
    issue(3'b100, 4'd3, 8'h00);
    chk("rol_busy0", bus.busy, 1'b1);
    chk("rol_q0", bus.q, 8'hA5);
    @(negedge clk);
    chk("rol_q1", bus.q, 8'h4B);
    @(negedge clk);
    chk("rol_q2", bus.q, 8'h96);
    chk("rol_done_early", bus.done, 1'b0);
    @(negedge clk);
    chk("rol_q3", bus.q, 8'h2D);
    chk("rol_done", bus.done, 1'b1);
    chk("rol_busy_end", bus.busy, 1'b0);
    // Back-to-back: request issued in the done cycle.
    issue(3'b001, 4'd0, 8'hA5);
    chk("b2b_q", bus.q, 8'hA5);
    chk("b2b_done", bus.done, 1'b1);
    @(negedge clk);
    chk("b2b_done_drop", bus.done, 1'b0);

    // ROR by WIDTH returns the original value.
    issue(3'b101, 4'd8, 8'h00);
    wait_done("ror8", bcnt, lat);
    chk("ror8_q", bus.q, 8'hA5);
    chk("ror8_busy_cycles", bcnt, 8);
    chk("ror8_latency", lat, 8);
    @(negedge clk);

    // Serial SHL streaming 1,0,1,1; a LOAD request while busy must be ignored.
    issue(3'b111, 4'd0, 8'hFF);
    chk("clr_q", bus.q, 8'h00);
    @(negedge clk);
    issue(3'b010, 4'd4, 8'h00);
    bus.sin_r = 1'b1;
    @(negedge clk);
    chk("ser_q1", bus.q, 8'h01);
    bus.sin_r = 1'b0;
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.din   = 8'h55;
    bus.amt   = 4'd0;
    @(negedge clk);
    chk("ser_q2", bus.q, 8'h02);
    bus.sin_r = 1'b1;
    @(negedge clk);
    chk("ser_q3", bus.q, 8'h05);
    bus.start = 1'b0;
    bus.sin_r = 1'b1;
    @(negedge clk);
    chk("ser_q4", bus.q, 8'h0B);
    chk("ser_sout_l", bus.sout_l, 1'b0);
    chk("ser_sout_r", bus.sout_r, 1'b1);
    chk("ser_done", bus.done, 1'b1);
    bus.sin_r = 1'b0;
    @(negedge clk);
    chk("ignored_q", bus.q, 8'h0B);
    chk("ignored_done", bus.done, 1'b0);
    chk("ignored_busy", bus.busy, 1'b0);

    // SHR by WIDTH fills entirely from sin_l.
    issue(3'b001, 4'd0, 8'h3C);
    @(negedge clk);
    bus.sin_l = 1'b1;
    issue(3'b011, 4'd8, 8'h00);
    wait_done("shr8", bcnt, lat);
    chk("shr8_q", bus.q, 8'hFF);
    bus.sin_l = 1'b0;
    @(negedge clk);

    // ASR with saturating amount.
    issue(3'b001, 4'd0, 8'h90);
    @(negedge clk);
    issue(3'b110, 4'd15, 8'h00);
    wait_done("asr_neg", bcnt, lat);
    chk("asr_neg_q", bus.q, 8'hFF);
    chk("asr_neg_busy_cycles", bcnt, 8);
    @(negedge clk);
    issue(3'b001, 4'd0, 8'h70);
    @(negedge clk);
    issue(3'b110, 4'd15, 8'h00);
    wait_done("asr_pos", bcnt, lat);
    chk("asr_pos_q", bus.q, 8'h00);
    chk("asr_pos_busy_cycles", bcnt, 8);
    @(negedge clk);

    // Zero-amount shift completes after one edge with q unchanged.
    issue(3'b001, 4'd0, 8'h3C);
    @(negedge clk);
    bus.sin_l = 1'b1;
    issue(3'b011, 4'd0, 8'h00);
    chk("amt0_q", bus.q, 8'h3C);
    chk("amt0_done", bus.done, 1'b1);
    chk("amt0_busy", bus.busy, 1'b0);
    bus.sin_l = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a rotate.
    issue(3'b001, 4'd0, 8'hA5);
    @(negedge clk);
    issue(3'b101, 4'd5, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", bus.q, 8'h00);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    @(negedge clk);
    chk("midrst_done_hold", bus.done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_q", bus.q, 8'h00);
    chk("postrst_done", bus.done, 1'b0);

`ifdef USR_PARITY_EN
    issue(3'b001, 4'd0, 8'h07);
    chk("par_load_q", bus.q, 8'h07);
    chk("par_load", bus.parity, 1'b1);
    @(negedge clk);
    bus.sin_r = 1'b0;
    issue(3'b010, 4'd1, 8'h00);
    @(negedge clk);
    chk("par_shl_q", bus.q, 8'h0E);
    chk("par_shl", bus.parity, 1'b1);
    @(negedge clk);
    issue(3'b111, 4'd0, 8'h00);
    chk("par_clr", bus.parity, 1'b0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
